// File: rtl/uart_host_controller.sv
// Host side of the sensor chip's UART link. Commands are serialized onto TXD.
// The chip's byte stream is parsed into 24-bit register frames and 56-bit ADS frames.

module uart_tx #(
  parameter logic [15:0] CLKS_PER_BIT = 16'd217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dv,
  input  logic [7:0] data,
  output logic       txd,
  output logic       done
);
  logic        busy_q;
  logic [15:0] cnt_q;
  logic [3:0]  left_q;
  logic [7:0]  shreg_q;
  logic        bit_end;

  assign bit_end = (cnt_q == CLKS_PER_BIT - 16'd1);

  // left_q counts the bit slots still to follow: eight data bits, then the stop bit.
  // NOTE: sequential state uses nonblocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      left_q  <= '0;
      shreg_q <= '0;
      txd     <= 1'b1;
    end else if (!busy_q) begin
      cnt_q <= '0;
      if (dv) begin
        busy_q  <= 1'b1;
        txd     <= 1'b0;
        shreg_q <= data;
        left_q  <= 4'd9;
      end
    end else if (!bit_end) begin
      cnt_q <= cnt_q + 16'd1;
    end else begin
      cnt_q <= '0;
      if (left_q == 4'd0) begin
        busy_q <= 1'b0;
      end else begin
        txd     <= shreg_q[0];
        shreg_q <= {1'b1, shreg_q[7:1]};
        left_q  <= left_q - 4'd1;
      end
    end
  end

  assign done = busy_q && bit_end && (left_q == 4'd0);
endmodule

module uart_rx #(
  parameter logic [15:0] CLKS_PER_BIT = 16'd217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       dv,
  output logic [7:0] data
);
  localparam logic [15:0] HALF = (CLKS_PER_BIT >> 1) - 16'd1;

  logic [1:0]  sync_q;
  logic        busy_q;
  logic [15:0] cnt_q;
  logic [3:0]  left_q;
  logic [7:0]  shreg_q;
  logic        rxd_s;

  assign rxd_s = sync_q[1];

  // Samples land mid-bit: start check at left_q=9, data at 8..1, stop at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      left_q  <= '0;
      shreg_q <= '0;
      dv      <= 1'b0;
      data    <= '0;
    end else begin
      sync_q <= {sync_q[0], rxd};
      dv     <= 1'b0;
      if (!busy_q) begin
        if (!rxd_s) begin
          busy_q <= 1'b1;
          cnt_q  <= HALF;
          left_q <= 4'd9;
        end
      end else if (cnt_q != 16'd0) begin
        cnt_q <= cnt_q - 16'd1;
      end else begin
        cnt_q  <= CLKS_PER_BIT - 16'd1;
        left_q <= left_q - 4'd1;
        if (left_q == 4'd9) begin
          if (rxd_s) busy_q <= 1'b0;
        end else if (left_q != 4'd0) begin
          shreg_q <= {rxd_s, shreg_q[7:1]};
        end else begin
          busy_q <= 1'b0;
          dv     <= 1'b1;
          data   <= shreg_q;
        end
      end
    end
  end
endmodule

module uart_host_controller #(
  parameter logic [15:0] UART_CLKS_PER_BIT = 16'd217,
  parameter logic [23:0] RX_TIMEOUT_CLKS   = 24'd43400
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic [15:0] i_CMD,
  input  logic        i_CMD_VALID,
  output logic        o_CMD_READY,
  output logic        o_CMD_ERR,
  output logic [55:0] o_FRAME_DATA,
  output logic        o_FRAME_VALID,
  output logic        o_RX_ERR,
  input  logic        i_UART_RXD,
  output logic        o_UART_TXD
);
  localparam logic [7:0] OP_RUN  = 8'h52;
  localparam logic [7:0] OP_STOP = 8'h53;
  localparam logic [7:0] OP_MPR  = 8'h6D;
  localparam logic [7:0] OP_ADS  = 8'h61;
  localparam logic [7:0] HDR_ADS = 8'hAA;

  typedef enum logic [1:0] {ST_TX_IDLE, ST_TX_LOAD, ST_TX_WAIT} tx_state_t;
  typedef enum logic {ST_RX_HDR, ST_RX_BODY} rx_state_t;

  function automatic logic [1:0] cmd_len(input logic [7:0] op);
    case (op)
      OP_RUN, OP_STOP: return 2'd1;
      OP_MPR, OP_ADS:  return 2'd2;
      default:         return 2'd0;
    endcase
  endfunction

  function automatic logic [2:0] hdr_len(input logic [7:0] hdr);
    case (hdr)
      HDR_ADS:        return 3'd7;
      OP_MPR, OP_ADS: return 3'd3;
      default:        return 3'd0;
    endcase
  endfunction

  // ---------------- TX path ----------------
  tx_state_t   tx_state_q, tx_state_d;
  logic [15:0] cmd_q, cmd_d;
  logic [1:0]  tx_len_q, tx_len_d, tx_cnt_q, tx_cnt_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        tx_dv_q, tx_dv_d, cmd_err_q, cmd_err_d, ready_en_q, tx_done;

  // ready_en_q holds READY low for the first cycle out of reset.
  assign o_CMD_READY = ready_en_q && (tx_state_q == ST_TX_IDLE);
  assign o_CMD_ERR   = cmd_err_q;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      tx_state_q <= ST_TX_IDLE;
      cmd_q      <= '0;
      tx_len_q   <= '0;
      tx_cnt_q   <= '0;
      tx_byte_q  <= '0;
      tx_dv_q    <= 1'b0;
      cmd_err_q  <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      cmd_q      <= cmd_d;
      tx_len_q   <= tx_len_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_byte_q  <= tx_byte_d;
      tx_dv_q    <= tx_dv_d;
      cmd_err_q  <= cmd_err_d;
      ready_en_q <= 1'b1;
    end
  end

  // An unsupported opcode gets length 0, so ST_TX_LOAD falls straight back to idle.
  // NOTE: every combinational output gets a default first, so no latch is inferred.
  always_comb begin
    tx_state_d = tx_state_q;
    cmd_d      = cmd_q;
    tx_len_d   = tx_len_q;
    tx_cnt_d   = tx_cnt_q;
    tx_byte_d  = tx_byte_q;
    tx_dv_d    = 1'b0;
    cmd_err_d  = 1'b0;
    unique case (tx_state_q)
      ST_TX_IDLE: if (i_CMD_VALID && o_CMD_READY) begin
        cmd_d      = i_CMD;
        tx_len_d   = cmd_len(i_CMD[15:8]);
        tx_cnt_d   = '0;
        cmd_err_d  = (cmd_len(i_CMD[15:8]) == 2'd0);
        tx_state_d = ST_TX_LOAD;
      end
      ST_TX_LOAD: if (tx_cnt_q == tx_len_q) begin
        tx_state_d = ST_TX_IDLE;
      end else begin
        tx_byte_d  = (tx_cnt_q == 2'd0) ? cmd_q[15:8] : cmd_q[7:0];
        tx_dv_d    = 1'b1;
        tx_cnt_d   = tx_cnt_q + 2'd1;
        tx_state_d = ST_TX_WAIT;
      end
      ST_TX_WAIT: if (tx_done) begin
        tx_state_d = (tx_cnt_q == tx_len_q) ? ST_TX_IDLE : ST_TX_LOAD;
      end
      default: tx_state_d = ST_TX_IDLE;
    endcase
  end

  uart_tx #(.CLKS_PER_BIT(UART_CLKS_PER_BIT)) u_tx (
    .clk (i_CLK),
    .rst (i_RST),
    .dv  (tx_dv_q),
    .data(tx_byte_q),
    .txd (o_UART_TXD),
    .done(tx_done)
  );

  // ---------------- RX path ----------------
  rx_state_t   rx_state_q, rx_state_d;
  logic [2:0]  rx_len_q, rx_len_d, rx_cnt_q, rx_cnt_d;
  logic [23:0] gap_q, gap_d;
  logic [55:0] asm_q, asm_d, frame_q, frame_d;
  logic        frame_valid_q, frame_valid_d, rx_err_q, rx_err_d, take_header;
  logic        rx_dv;
  logic [7:0]  rx_byte;

  assign o_FRAME_DATA  = frame_q;
  assign o_FRAME_VALID = frame_valid_q;
  assign o_RX_ERR      = rx_err_q;

  uart_rx #(.CLKS_PER_BIT(UART_CLKS_PER_BIT)) u_rx (
    .clk (i_CLK),
    .rst (i_RST),
    .rxd (i_UART_RXD),
    .dv  (rx_dv),
    .data(rx_byte)
  );

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      rx_state_q    <= ST_RX_HDR;
      rx_len_q      <= '0;
      rx_cnt_q      <= '0;
      gap_q         <= '0;
      asm_q         <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      rx_err_q      <= 1'b0;
    end else begin
      rx_state_q    <= rx_state_d;
      rx_len_q      <= rx_len_d;
      rx_cnt_q      <= rx_cnt_d;
      gap_q         <= gap_d;
      asm_q         <= asm_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      rx_err_q      <= rx_err_d;
    end
  end

  // Frames assemble in asm_q; frame_q only changes when a frame completes.
  // A timeout is handled first, so a byte landing in the same cycle starts a new frame.
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_len_d      = rx_len_q;
    rx_cnt_d      = rx_cnt_q;
    gap_d         = gap_q;
    asm_d         = asm_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    rx_err_d      = 1'b0;
    take_header   = 1'b0;
    unique case (rx_state_q)
      ST_RX_HDR: take_header = rx_dv;
      ST_RX_BODY: begin
        if (gap_q == RX_TIMEOUT_CLKS) begin
          rx_err_d    = 1'b1;
          gap_d       = '0;
          rx_state_d  = ST_RX_HDR;
          take_header = rx_dv;
        end else if (rx_dv) begin
          asm_d[{3'd6 - rx_cnt_q, 3'b000} +: 8] = rx_byte;
          rx_cnt_d = rx_cnt_q + 3'd1;
          gap_d    = '0;
          if (rx_cnt_d == rx_len_q) begin
            frame_d       = asm_d;
            frame_valid_d = 1'b1;
            rx_state_d    = ST_RX_HDR;
          end
        end else begin
          gap_d = gap_q + 24'd1;
        end
      end
      default: rx_state_d = ST_RX_HDR;
    endcase
    if (take_header) begin
      rx_len_d = hdr_len(rx_byte);
      if (rx_len_d == 3'd0) begin
        rx_err_d = 1'b1;
      end else begin
        asm_d      = {rx_byte, 48'h0};
        rx_cnt_d   = 3'd1;
        gap_d      = '0;
        rx_state_d = ST_RX_BODY;
      end
    end
  end
endmodule

// File: tb/tb_uart_host_controller.sv
// Directed bench for uart_host_controller: command serialization, frame parsing,
// error pulses, timeout and mid-transfer reset, with a short bit period.
`timescale 1ns/1ps

module tb_uart_host_controller;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cmd = '0;
  logic        cmd_valid = 1'b0;
  logic        rxd = 1'b1;
  logic        cmd_ready, cmd_err, frame_valid, rx_err, txd;
  logic [55:0] frame_data;

  int checks = 0;
  int failures = 0;
  int vld_cnt = 0;
  int rxerr_cnt = 0;
  int cmderr_cnt = 0;
  logic [55:0] frames [0:7];
  logic        txd_log [0:511];

  uart_host_controller #(
    .UART_CLKS_PER_BIT(16'd4),
    .RX_TIMEOUT_CLKS  (24'd200)
  ) dut (
    .i_CLK        (clk),
    .i_RST        (rst),
    .i_CMD        (cmd),
    .i_CMD_VALID  (cmd_valid),
    .o_CMD_READY  (cmd_ready),
    .o_CMD_ERR    (cmd_err),
    .o_FRAME_DATA (frame_data),
    .o_FRAME_VALID(frame_valid),
    .o_RX_ERR     (rx_err),
    .i_UART_RXD   (rxd),
    .o_UART_TXD   (txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled on the falling edge and pulses are tallied.
  task automatic tick();
    @(negedge clk);
    if (frame_valid === 1'b1) begin
      if (vld_cnt < 8) frames[vld_cnt] = frame_data;
      vld_cnt++;
    end
    if (rx_err === 1'b1) rxerr_cnt++;
    if (cmd_err === 1'b1) cmderr_cnt++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      repeat (CPB) tick();
    end
  endtask

  // Issue a command, then log TXD every cycle while READY is low (bounded).
  task automatic issue_and_log(input logic [15:0] c, output int n);
    cmd = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd = 16'hFFFF;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 512) begin
      txd_log[n] = txd;
      n++;
      tick();
    end
  endtask

  task automatic decode(input int from, output logic [7:0] b, output logic stop_bit, output int start);
    start = from;
    while (start < 400 && txd_log[start] !== 1'b0) start++;
    for (int k = 0; k < 8; k++) b[k] = txd_log[start + 6 + 4 * k];
    stop_bit = txd_log[start + 38];
  endtask

  initial begin
    int n, s1, s2, zeros;
    logic [7:0] b;
    logic sb;

    repeat (3) tick();
    check("rst_ready", cmd_ready, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_frame_data", frame_data, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_rx_err", rx_err, 0);
    check("rst_txd", txd, 1);
    rst = 1'b0;
    tick();
    check("ready_after_reset", cmd_ready, 1);

    issue_and_log(16'h5200, n);
    check("run_busy_cycles", n, 42);
    decode(0, b, sb, s1);
    check("run_start_idx", s1, 2);
    check("run_byte", b, 8'h52);
    check("run_stop", sb, 1);

    issue_and_log(16'h6D1F, n);
    check("mpr_busy_cycles", n, 84);
    decode(0, b, sb, s1);
    check("mpr_byte0", b, 8'h6D);
    check("mpr_stop0", sb, 1);
    decode(s1 + 40, b, sb, s2);
    check("mpr_byte_cost", s2 - s1, 42);
    check("mpr_byte1", b, 8'h1F);
    check("mpr_stop1", sb, 1);
    check("legal_no_cmd_err", cmderr_cnt, 0);

    send_byte(8'h6D); send_byte(8'h1F); send_byte(8'hA5);
    repeat (8) tick();
    check("mpr_frame_count", vld_cnt, 1);
    check("mpr_frame", frames[0], 56'h6D1FA500000000);
    check("mpr_frame_data_hold", frame_data, 56'h6D1FA500000000);

    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h04); send_byte(8'h05); send_byte(8'h06);
    send_byte(8'hAA); send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C);
    send_byte(8'h0D); send_byte(8'h0E); send_byte(8'h0F);
    repeat (8) tick();
    check("ads_frame_count", vld_cnt, 3);
    check("ads_frame_a", frames[1], 56'hAA010203040506);
    check("ads_frame_b", frames[2], 56'hAA0A0B0C0D0E0F);
    check("ads_no_rx_err", rxerr_cnt, 0);

    send_byte(8'h33);
    repeat (4) tick();
    check("bad_hdr_err", rxerr_cnt, 1);
    send_byte(8'h61); send_byte(8'h02); send_byte(8'h7E);
    repeat (8) tick();
    check("reg_frame_count", vld_cnt, 4);
    check("reg_frame", frames[3], 56'h61027E00000000);

    send_byte(8'hAA); send_byte(8'h11); send_byte(8'h22);
    rxd = 1'b1;
    repeat (260) tick();
    check("timeout_err", rxerr_cnt, 2);
    check("timeout_no_frame", vld_cnt, 4);
    check("timeout_data_kept", frame_data, 56'h61027E00000000);
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
    send_byte(8'h40); send_byte(8'h50); send_byte(8'h60);
    repeat (8) tick();
    check("post_timeout_count", vld_cnt, 5);
    check("post_timeout_frame", frames[4], 56'hAA102030405060);
    check("post_timeout_no_err", rxerr_cnt, 2);

    cmd = 16'h7700;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("illegal_err_pulse", cmd_err, 1);
    check("illegal_ready_low", cmd_ready, 0);
    tick();
    check("illegal_err_clear", cmd_err, 0);
    check("illegal_ready_back", cmd_ready, 1);
    zeros = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (txd !== 1'b1) zeros++;
    end
    check("illegal_txd_idle", zeros, 0);
    check("illegal_err_count", cmderr_cnt, 1);

    // Partial RX frame in progress plus TX of 0x61 in flight, then reset.
    send_byte(8'hAA);
    repeat (8) tick();
    cmd = 16'h6155;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (20) tick();
    check("midtx_busy", cmd_ready, 0);
    rst = 1'b1;
    #1;
    check("midrst_txd", txd, 1);
    check("midrst_ready", cmd_ready, 0);
    check("midrst_frame_data", frame_data, 0);
    check("midrst_frame_valid", frame_valid, 0);
    check("midrst_rx_err", rx_err, 0);
    check("midrst_cmd_err", cmd_err, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("midrst_ready_back", cmd_ready, 1);
    zeros = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (txd !== 1'b1) zeros++;
    end
    check("midrst_txd_idle", zeros, 0);
    check("midrst_no_frame", vld_cnt, 5);
    check("midrst_no_rx_err", rxerr_cnt, 2);

    issue_and_log(16'h5300, n);
    check("stop_busy_cycles", n, 42);
    decode(0, b, sb, s1);
    check("stop_byte", b, 8'h53);
    check("stop_stop", sb, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_host_controller.md
# uart_host_controller

Host-side counterpart of the sensor chip's UART command/stream link, used in the FPGA host bridge and as the chip-level verification partner. It serializes host commands (run, stop, MPR and ADS register reads) onto the UART TX line. It also parses the chip's returned byte stream into 24-bit register frames and 56-bit ADS data frames. TX and RX operate independently (full duplex), built on the codebase's `uart_tx`/`uart_rx` cores.

## Interface
- UART_CLKS_PER_BIT, 16'd217, bit period in i_CLK cycles (25 MHz / 115200)
- RX_TIMEOUT_CLKS, 24'd43400, maximum idle cycles between bytes inside a frame (about 20 byte times)
- i_CLK  in  1  clock
- i_RST  in  1  reset, asynchronous, active-high
- i_CMD  in  16  [15:8] opcode, [7:0] register address (used for read opcodes only)
- i_CMD_VALID  in  1  command request
- o_CMD_READY  out  1  command accepted when high together with i_CMD_VALID
- o_CMD_ERR  out  1  one-cycle pulse: unsupported opcode dropped
- o_FRAME_DATA  out  56  received frame; header byte in [55:48], later bytes in descending order, unused low bits zero
- o_FRAME_VALID  out  1  one-cycle pulse, o_FRAME_DATA valid
- o_RX_ERR  out  1  one-cycle pulse: bad header byte or intra-frame timeout
- i_UART_RXD  in  1  serial from chip
- o_UART_TXD  out  1  serial to chip

## Operation
- Opcodes: 'R' 8'h52 and 'S' 8'h53 send 1 byte. 'm' 8'h6D and 'a' 8'h61 send 2 bytes: opcode first, then address.
- Any other opcode is still accepted. It sends nothing and pulses o_CMD_ERR the cycle after acceptance.
- TX FSM states:
  - ST_TX_IDLE: ready=1. On valid&ready, latch i_CMD, clear the byte counter, go to ST_TX_LOAD.
  - ST_TX_LOAD: drive the next byte to `uart_tx` with a one-cycle DV pulse, go to ST_TX_WAIT.
  - ST_TX_WAIT: on o_Tx_Done, if bytes remain go to ST_TX_LOAD, else go to ST_TX_IDLE.
- RX FSM states:
  - ST_RX_HDR: on Rx_DV, 8'hAA sets the expected length to 7 bytes and 'a'/'m' set it to 3 bytes. The header is stored in [55:48], lower bits are cleared, and the FSM goes to ST_RX_BODY. Any other byte is discarded with an o_RX_ERR pulse, and the FSM stays in ST_RX_HDR.
  - ST_RX_BODY: each Rx_DV stores the byte at the next lower byte lane and resets the gap counter. After the last byte, pulse o_FRAME_VALID and return to ST_RX_HDR.
- Gap counter: 24-bit, increments every cycle in ST_RX_BODY without Rx_DV. When it reaches RX_TIMEOUT_CLKS, the partial frame is dropped, o_RX_ERR pulses, and the FSM returns to ST_RX_HDR. o_FRAME_DATA keeps its last completed value.
- 24-bit frames: o_FRAME_DATA[31:0] = 0.
- Byte counter: 3-bit, counts received bytes including the header; it does not wrap within a frame.
- Command stop/run gating is the chip's responsibility. The host sends every legal command unconditionally.

## Timing
- Reset values:
  - o_CMD_READY=0, o_CMD_ERR=0, o_FRAME_DATA=0, o_FRAME_VALID=0, o_RX_ERR=0, o_UART_TXD=1.
  - Both FSMs are in their idle/header state; all counters are 0.
- o_CMD_READY rises on the first clock after reset deassertion. It falls the cycle after acceptance.
- After a legal command, o_CMD_READY returns high the cycle after the final o_Tx_Done.
- After an illegal opcode, o_CMD_READY returns high 2 cycles after acceptance.
- Byte cost: 10 × UART_CLKS_PER_BIT cycles plus 2 cycles of FSM overhead. TX DV is asserted the cycle after ST_TX_LOAD is entered.
- Frame latency: o_FRAME_VALID is asserted one cycle after the `uart_rx` DV of the last byte. o_FRAME_DATA is stable from that cycle until the next frame completes.
- i_CMD changes while busy are ignored; the command is latched only at acceptance.
- TX and RX events in the same cycle are both serviced; there is no arbitration.
- A header byte arriving while a timeout fires in the same cycle: the timeout is processed first, and the byte is taken as a new header.
- Reset mid-frame or mid-byte: everything returns to reset values immediately, and o_UART_TXD goes to 1. No partial frame is ever reported.

## Test plan
- UART_CLKS_PER_BIT=4. Command 16'h5200 -> one TXD byte 0x52 (start bit, 8 bits LSB-first, stop bit). ready is low for 40+2 cycles.
- Command 16'h6D1F -> bytes 0x6D then 0x1F. Chip model replies 6D 1F A5 -> o_FRAME_DATA=56'h6D1FA500000000, one-cycle o_FRAME_VALID.
- RX stream AA 01 02 03 04 05 06 -> o_FRAME_DATA=56'hAA010203040506. A second back-to-back frame is also captured, with no error.
- RX byte 0x33, then 61 02 7E -> o_RX_ERR pulse on 0x33, then frame 56'h61027E00000000.
- RX AA 11 22, then line idle for more than RX_TIMEOUT_CLKS -> o_RX_ERR pulse, no o_FRAME_VALID, previous o_FRAME_DATA retained. Next AA frame parses correctly.
- Command 16'h7700 -> o_CMD_ERR pulse, TXD stays 1. Assert reset mid-transmission of 0x61 -> TXD=1 and all outputs at reset values.
